// File: rtl/myproject_dense_acc_21s_16s_if.sv
// Stream bundle for the dense-layer accumulation stage: signed products in, requantised results out.
// Both streams are valid/ready: a transfer happens on a rising edge with valid && ready, and the sender holds its data stable while valid && !ready.
interface myproject_dense_acc_21s_16s_if #(
    parameter int PROD_WIDTH = 21,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [BIAS_WIDTH-1:0] bias;
    logic signed [OUT_WIDTH-1:0]  res_data;
    logic                         res_sat;
    logic                         res_valid;
    logic                         res_ready;

    modport master (
        output prod_data, prod_valid, bias, res_ready,
        input  prod_ready, res_data, res_sat, res_valid
    );

    modport slave (
        input  prod_data, prod_valid, bias, res_ready,
        output prod_ready, res_data, res_sat, res_valid
    );
endinterface

// File: rtl/myproject_dense_acc_21s_16s.sv
// Dense-layer accumulator: sums N_IN signed products plus bias, then rounds half-up,
// drops SHIFT fractional bits and saturates to OUT_WIDTH, one result per group.
module myproject_dense_acc_21s_16s #(
    parameter int PROD_WIDTH = 21,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 26,
    parameter int N_IN       = 4,
    parameter int SHIFT      = 5,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    myproject_dense_acc_21s_16s_if.slave   io,
    output logic [7:0]                     dbg_cnt
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    // cnt == GROUP_START means the next beat reloads the accumulator from bias.
    localparam logic [CNT_W-1:0] GROUP_START = '0;
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(N_IN - 1);

    localparam logic signed [ACC_WIDTH:0] HALF    = (ACC_WIDTH + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        res_valid_q, res_valid_d;
    logic signed [OUT_WIDTH-1:0] res_data_q, res_data_d;
    logic                        res_sat_q, res_sat_d;

    logic                        prod_ready;
    logic                        accept;
    logic                        consume;
    logic                        is_start;
    logic                        is_last;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [ACC_WIDTH:0]   shifted;

    always_comb begin
        is_start = (cnt_q == GROUP_START);
        is_last  = (cnt_q == LAST_BEAT);
        // Only the final beat of a group can stall, and only while the held result is unclaimed.
        prod_ready = !(is_last && res_valid_q && !io.res_ready);
        accept     = io.prod_valid && prod_ready;
        consume    = res_valid_q && io.res_ready;

        prod_ext = ACC_WIDTH'(io.prod_data);
        bias_ext = ACC_WIDTH'(io.bias);
        base     = is_start ? bias_ext : acc_q;
        sum      = base + prod_ext;
        rounded  = {sum[ACC_WIDTH-1], sum} + HALF;
        shifted  = rounded >>> SHIFT;

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sat_d   = res_sat_q;

        if (consume) begin
            res_valid_d = 1'b0;
        end

        if (accept) begin
            acc_d = sum;
            cnt_d = is_last ? GROUP_START : cnt_q + CNT_W'(1);
            if (is_last) begin
                res_valid_d = 1'b1;
                if (shifted > OUT_MAX) begin
                    res_data_d = OUT_MAX[OUT_WIDTH-1:0];
                    res_sat_d  = 1'b1;
                end else if (shifted < OUT_MIN) begin
                    res_data_d = OUT_MIN[OUT_WIDTH-1:0];
                    res_sat_d  = 1'b1;
                end else begin
                    res_data_d = shifted[OUT_WIDTH-1:0];
                    res_sat_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_q       <= GROUP_START;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sat_q   <= res_sat_d;
        end
    end

    assign io.prod_ready = prod_ready;
    assign io.res_valid  = res_valid_q;
    assign io.res_data   = res_data_q;
    assign io.res_sat    = res_sat_q;
    assign dbg_cnt       = 8'(cnt_q);
endmodule

// File: tb/tb_myproject_dense_acc_21s_16s.sv
// Bench for the dense accumulator: directed scenarios plus randomized groups, checked through
// expected-result queues filled by a plain-arithmetic reference model.
module tb_myproject_dense_acc_21s_16s;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic [7:0] dbg_a;
    logic [7:0] dbg_b;

    myproject_dense_acc_21s_16s_if a ();
    myproject_dense_acc_21s_16s_if b ();

    myproject_dense_acc_21s_16s dut_a (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .io      (a),
        .dbg_cnt (dbg_a)
    );

    myproject_dense_acc_21s_16s #(.N_IN(1)) dut_b (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .io      (b),
        .dbg_cnt (dbg_b)
    );

    // clock / reset
    always #5 ap_clk = ~ap_clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         stall_total = 0;
    bit         rr_rand = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_b_q[$];
    longint     grp_q[$];
    longint     grp_bias;
    int         cons_cyc_q[$];

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: floor((sum + 16) / 32) clipped to 16-bit signed; returns {sat, data}.
    function automatic logic [16:0] model(input longint sum);
        longint q;
        longint r;
        logic   s;
        q = sum + 16;
        if (q >= 0) r = q / 32;
        else        r = -((-q + 31) / 32);
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return {s, 16'(r)};
    endfunction

    // driver: called at a negedge, returns right after the accepting posedge
    task automatic send_a(input longint p, input longint bi, output int stalls);
        bit ok;
        bit done;
        longint s;
        stalls = 0;
        done = 1'b0;
        a.prod_valid = 1'b1;
        a.prod_data  = 21'(p);
        a.bias       = 16'(bi);
        while (!done) begin
            #4;
            ok = a.prod_ready;
            @(posedge ap_clk);
            if (ok) begin
                done = 1'b1;
                if (grp_q.size() == 0) grp_bias = bi;
                grp_q.push_back(p);
                if (grp_q.size() == 4) begin
                    s = grp_bias;
                    foreach (grp_q[i]) s += grp_q[i];
                    exp_q.push_back(model(s));
                    grp_q.delete();
                end
            end else begin
                stalls++;
                if (stalls > 200) begin
                    fail_now("accept_timeout");
                    done = 1'b1;
                end else begin
                    @(negedge ap_clk);
                end
            end
        end
    endtask

    task automatic beat_a(input longint p, input longint bi);
        int st;
        @(negedge ap_clk);
        send_a(p, bi, st);
        stall_total += st;
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge ap_clk);
            a.prod_valid = 1'b0;
            a.prod_data  = 21'($urandom);
            a.bias       = 16'($urandom);
        end
    endtask

    task automatic beat_b(input longint p, input longint bi);
        bit ok;
        @(negedge ap_clk);
        b.prod_valid = 1'b1;
        b.prod_data  = 21'(p);
        b.bias       = 16'(bi);
        #4;
        ok = b.prod_ready;
        check("b_prod_ready", ok, 1);
        @(posedge ap_clk);
        exp_b_q.push_back(model(p + bi));
        #1;
        check("b_latency_valid", b.res_valid, 1);
        @(negedge ap_clk);
        b.prod_valid = 1'b0;
    endtask

    // scoreboard monitors: compare on every consumed result, just before the edge
    always @(negedge ap_clk) begin
        logic [16:0] e;
        #4;
        if (!ap_rst && a.res_valid && a.res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_result: got %0d, expected none", a.res_data);
            end else begin
                e = exp_q.pop_front();
                check("a_res_data", a.res_data, $signed(e[15:0]));
                check("a_res_sat", a.res_sat, e[16]);
                cons_cyc_q.push_back(cyc);
            end
        end
    end

    always @(negedge ap_clk) begin
        logic [16:0] e;
        #4;
        if (!ap_rst && b.res_valid && b.res_ready) begin
            if (exp_b_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_result: got %0d, expected none", b.res_data);
            end else begin
                e = exp_b_q.pop_front();
                check("b_res_data", b.res_data, $signed(e[15:0]));
                check("b_res_sat", b.res_sat, e[16]);
            end
        end
    end

    always @(negedge ap_clk) begin
        if (rr_rand) a.res_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic drain_a();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 200)) begin
            @(negedge ap_clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        int st;
        bit sat_grp;
        longint p;
        longint bi;

        a.prod_valid = 1'b0; a.prod_data = '0; a.bias = '0; a.res_ready = 1'b1;
        b.prod_valid = 1'b0; b.prod_data = '0; b.bias = '0; b.res_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_res_valid", a.res_valid, 0);
        check("rst_res_data", a.res_data, 0);
        check("rst_res_sat", a.res_sat, 0);
        check("rst_cnt", dbg_a, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check("rst_prod_ready", a.prod_ready, 1);
        check("rst_b_prod_ready", b.prod_ready, 1);

        // 1: basic sum with latency check
        for (int i = 0; i < 3; i++) beat_a(32, 0);
        #1;
        check("basic_not_early", a.res_valid, 0);
        beat_a(32, 0);
        #1;
        check("basic_latency_valid", a.res_valid, 1);
        check("basic_data", a.res_data, 4);
        check("basic_sat", a.res_sat, 0);
        idle_a(2);

        // 2: rounding
        beat_b(16, 0);
        beat_b(-16, 0);
        beat_b(-17, 0);
        for (int i = 0; i < 4; i++) beat_a(0, (i == 0) ? -64 : 123);
        idle_a(2);

        // 3: saturation
        for (int i = 0; i < 4; i++) beat_a(1048575, 0);
        for (int i = 0; i < 4; i++) beat_a(-1048576, 0);
        idle_a(2);
        drain_a();

        // 4: backpressure
        @(negedge ap_clk);
        a.res_ready = 1'b0;
        stall_total = 0;
        for (int i = 0; i < 4; i++) beat_a(32, 0);
        for (int i = 0; i < 3; i++) beat_a(64, 0);
        check("bp_no_early_stall", stall_total, 0);
        @(negedge ap_clk);
        a.prod_valid = 1'b1;
        a.prod_data  = 21'(64);
        for (int i = 0; i < 3; i++) begin
            #4;
            check("bp_prod_ready_low", a.prod_ready, 0);
            check("bp_held_data", a.res_data, 4);
            check("bp_held_valid", a.res_valid, 1);
            @(negedge ap_clk);
        end
        a.res_ready = 1'b1;
        send_a(64, 0, st);
        check("bp_final_stalls", st, 0);
        #1;
        check("bp_valid_kept", a.res_valid, 1);
        check("bp_new_data", a.res_data, 8);
        idle_a(2);
        drain_a();

        // 5: reset mid-group with a pending result
        @(negedge ap_clk);
        a.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat_a(32, 0);
        beat_a(1000, 500);
        beat_a(1000, 0);
        @(negedge ap_clk);
        a.prod_valid = 1'b0;
        ap_rst = 1'b1;
        exp_q.delete();
        grp_q.delete();
        @(posedge ap_clk);
        #1;
        check("rst_mid_valid", a.res_valid, 0);
        check("rst_mid_cnt", dbg_a, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        a.res_ready = 1'b1;
        #1;
        check("rst_mid_valid_after", a.res_valid, 0);
        for (int i = 0; i < 4; i++) beat_a(32, 0);
        idle_a(2);
        drain_a();

        // 6: back-to-back groups
        stall_total = 0;
        cons_cyc_q.delete();
        for (int i = 0; i < 12; i++) beat_a(32, 0);
        idle_a(3);
        check("b2b_stalls", stall_total, 0);
        check("b2b_results", cons_cyc_q.size(), 3);
        if (cons_cyc_q.size() == 3) begin
            check("b2b_spacing_1", cons_cyc_q[1] - cons_cyc_q[0], 4);
            check("b2b_spacing_2", cons_cyc_q[2] - cons_cyc_q[1], 4);
        end

        // random groups with random gaps and random downstream backpressure
        rr_rand = 1'b1;
        for (int g = 0; g < 40; g++) begin
            sat_grp = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < 4; k++) begin
                if (sat_grp) p = ($urandom_range(0, 1) == 1) ? 1048575 : -1048576;
                else         p = longint'($urandom_range(0, 2097151)) - 1048576;
                bi = longint'($urandom_range(0, 65535)) - 32768;
                if ($urandom_range(0, 3) == 0) idle_a($urandom_range(1, 2));
                beat_a(p, bi);
            end
        end
        idle_a(1);
        rr_rand = 1'b0;
        @(negedge ap_clk);
        a.res_ready = 1'b1;
        drain_a();
        idle_a(2);

        check("end_a_queue_empty", exp_q.size(), 0);
        check("end_b_queue_empty", exp_b_q.size(), 0);
        check("end_partial_group", grp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
